// File: rtl/trace_pkg.sv
// Shared types for the trace UART transmit scheduler.
package trace_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_HOLD
    } trace_sched_state_t;

    localparam logic [15:0] TRACE_LOCK_TIMEOUT_DEFAULT = 16'd50000;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first valid at or after ptr_i, wrapping.
module rr_pick #(
    parameter int unsigned N  = 2,
    parameter int unsigned PW = $clog2(N)
) (
    input  logic [N-1:0]  valid_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  winner_o,
    output logic          any_o
);

    int idx;

    // Scan farthest-first so the candidate nearest the pointer wins.
    always_comb begin
        idx      = 0;
        winner_o = '0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            idx = int'(ptr_i) + k;
            if (idx >= int'(N)) idx = idx - int'(N);
            if (valid_i[idx]) begin
                winner_o      = '0;
                winner_o[idx] = 1'b1;
            end
        end
    end

    assign any_o = |valid_i;

endmodule

// File: rtl/trace_tx_sched.sv
// Round-robin byte scheduler feeding the trace UART serializer;
// the grant stays locked on one requester until its packet ends.
module trace_tx_sched
    import trace_pkg::*;
#(
    parameter int unsigned NREQ         = 2,
    parameter logic [15:0] LOCK_TIMEOUT = TRACE_LOCK_TIMEOUT_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NREQ-1:0]   req_valid_i,
    input  logic [NREQ*8-1:0] req_data_i,
    input  logic [NREQ-1:0]   req_last_i,
    output logic [NREQ-1:0]   req_ready_o,
    output logic [7:0]        tx_data_o,
    output logic              tx_start_o,
    input  logic              tx_done_i,
    output logic [NREQ-1:0]   grant_o,
    output logic              busy_o,
    output logic              lock_timeout_o
);

    localparam int unsigned PW = $clog2(NREQ);

    trace_sched_state_t state_q;

    logic [PW-1:0]   rr_ptr_q;
    logic [PW-1:0]   owner_q;
    logic [PW-1:0]   win_idx;
    logic [PW-1:0]   sel_idx;
    logic [PW-1:0]   ptr_next;
    logic [NREQ-1:0] win_oh;
    logic            any_valid;
    logic            last_q;
    logic            accept_idle;
    logic            hold_xfer;
    logic            lock_expired;
    logic [15:0]     lock_cnt_q;
    logic [7:0]      sel_data;
    logic            sel_last;

    rr_pick #(
        .N  (NREQ),
        .PW (PW)
    ) u_pick (
        .valid_i  (req_valid_i),
        .ptr_i    (rr_ptr_q),
        .winner_o (win_oh),
        .any_o    (any_valid)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < int'(NREQ); i++)
            if (win_oh[i]) win_idx = PW'(i);
    end

    assign accept_idle  = (state_q == ST_IDLE) && any_valid && tx_done_i;
    assign hold_xfer    = (state_q == ST_HOLD) && req_valid_i[owner_q];
    assign lock_expired = (LOCK_TIMEOUT != 16'd0) &&
                          (lock_cnt_q == LOCK_TIMEOUT - 16'd1);

    assign sel_idx  = (state_q == ST_HOLD) ? owner_q : win_idx;
    assign sel_data = req_data_i[{sel_idx, 3'b000} +: 8];
    assign sel_last = req_last_i[sel_idx];
    assign ptr_next = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + PW'(1);

    // Ready is gated by reset so nothing is accepted while held in reset.
    always_comb begin
        req_ready_o = '0;
        if (rst_ni) begin
            if (accept_idle)
                req_ready_o = win_oh;
            else if (state_q == ST_HOLD)
                req_ready_o = grant_o & req_valid_i;
        end
    end

    assign busy_o = (state_q != ST_IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= ST_IDLE;
            rr_ptr_q       <= '0;
            owner_q        <= '0;
            last_q         <= 1'b0;
            lock_cnt_q     <= '0;
            tx_data_o      <= '0;
            tx_start_o     <= 1'b0;
            grant_o        <= '0;
            lock_timeout_o <= 1'b0;
        end else begin
            tx_start_o     <= 1'b0;
            lock_timeout_o <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (accept_idle) begin
                        tx_data_o  <= sel_data;
                        last_q     <= sel_last;
                        owner_q    <= win_idx;
                        grant_o    <= win_oh;
                        tx_start_o <= 1'b1;
                        state_q    <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: state_q <= ST_WAIT_BUSY;
                // Done is still high right after start; wait for it to drop.
                ST_WAIT_BUSY: begin
                    if (!tx_done_i) state_q <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (tx_done_i) begin
                        if (last_q) begin
                            rr_ptr_q <= ptr_next;
                            grant_o  <= '0;
                            state_q  <= ST_IDLE;
                        end else begin
                            lock_cnt_q <= '0;
                            state_q    <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (hold_xfer) begin
                        tx_data_o  <= sel_data;
                        last_q     <= sel_last;
                        tx_start_o <= 1'b1;
                        state_q    <= ST_LAUNCH;
                    end else if (lock_expired) begin
                        lock_timeout_o <= 1'b1;
                        rr_ptr_q       <= ptr_next;
                        grant_o        <= '0;
                        state_q        <= ST_IDLE;
                    end else begin
                        lock_cnt_q <= lock_cnt_q + 16'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_trace_tx_sched.sv
// Randomized bench for trace_tx_sched against a packet-level model.
module tb_trace_tx_sched;

    localparam int          NREQ = 3;
    localparam logic [15:0] TMO  = 16'd20;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*8-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic [7:0]        tx_data;
    logic              tx_start;
    logic              tx_done;
    logic [NREQ-1:0]   grant;
    logic              busy;
    logic              lock_to;

    always #5 clk = ~clk;

    trace_tx_sched #(
        .NREQ         (NREQ),
        .LOCK_TIMEOUT (TMO)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .req_valid_i    (req_valid),
        .req_data_i     (req_data),
        .req_last_i     (req_last),
        .req_ready_o    (req_ready),
        .tx_data_o      (tx_data),
        .tx_start_o     (tx_start),
        .tx_done_i      (tx_done),
        .grant_o        (grant),
        .busy_o         (busy),
        .lock_timeout_o (lock_to)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
        end
    endtask

    logic [8:0]      rq[NREQ][$];
    logic [8:0]      mq[NREQ][$];
    logic [7:0]      line[$];
    logic [7:0]      exp_q[$];
    logic [NREQ-1:0] en;
    logic [NREQ-1:0] xfer;
    logic [NREQ-1:0] g_first;
    logic [7:0]      prev_data;
    bit              prev_any;
    bit              ser_act;
    bit              hold_low;
    int              hi_left, lo_left;
    int              cyc, done_rise, to_delay;
    int              n_start, n_start_busy, n_multi, n_bad_grant;
    int              n_ready_cyc, n_r1_early, n_unstable, n_to;

    task automatic clr_stats();
        n_start = 0; n_start_busy = 0; n_multi = 0; n_bad_grant = 0;
        n_ready_cyc = 0; n_r1_early = 0; n_unstable = 0; n_to = 0;
        to_delay = 0; g_first = '0;
        line.delete();
    endtask

    // One clock: retire transfers, advance serializer model, drive, sample.
    task automatic step();
        logic [8:0] hd;
        @(negedge clk);
        cyc++;
        for (int i = 0; i < NREQ; i++)
            if (xfer[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        if (tx_start) begin
            n_start++;
            if (ser_act) n_start_busy++;
            else begin
                line.push_back(tx_data);
                ser_act = 1'b1;
                hi_left = $urandom_range(5, 2);
                lo_left = $urandom_range(6, 2);
            end
        end else if (ser_act) begin
            if (hi_left > 0) hi_left--;
            else if (lo_left > 1) lo_left--;
            else begin
                ser_act   = 1'b0;
                done_rise = cyc;
            end
        end
        tx_done = !(hold_low || (ser_act && hi_left == 0));
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = en[i] && (rq[i].size() > 0);
            if (rq[i].size() > 0) begin
                hd = rq[i][0];
                req_data[i*8 +: 8] = hd[7:0];
                req_last[i] = hd[8];
            end
        end
        #1;
        xfer = req_ready & req_valid;
        if (lock_to) begin
            n_to++;
            to_delay = cyc - done_rise;
        end
        if ($countones(req_ready) > 1) n_multi++;
        if (!$onehot0(grant)) n_bad_grant++;
        if (grant != '0 && (req_ready & ~grant) != '0) n_bad_grant++;
        if (ser_act && req_ready != '0) n_bad_grant++;
        if (req_ready != '0) n_ready_cyc++;
        if (req_ready[1] && n_to == 0) n_r1_early++;
        if (tx_data != prev_data && !prev_any) n_unstable++;
        prev_data = tx_data;
        prev_any  = (xfer != '0);
        if (g_first == '0) g_first = grant;
    endtask

    function automatic bit drained();
        for (int i = 0; i < NREQ; i++)
            if (en[i] && rq[i].size() > 0) return 1'b0;
        return !ser_act && !busy && !hold_low;
    endfunction

    task automatic run_until_idle(input int budget, input string tag);
        int k = 0;
        while (k < budget && !drained()) begin
            step();
            k++;
        end
        check({tag, "_drain"}, 32'(k < budget), 32'd1);
    endtask

    task automatic check_line(input string tag);
        check({tag, "_len"}, 32'(line.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < line.size(); i++)
            check({tag, "_byte"}, 32'(line[i]), 32'(exp_q[i]));
    endtask

    // Reset asserted away from the clock edge; outputs must clear at once.
    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_start", 32'(tx_start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tmo", 32'(lock_to), 32'd0);
        check("rst_data", 32'(tx_data), 32'd0);
        for (int i = 0; i < NREQ; i++) rq[i].delete();
        en = '0; xfer = '0;
        req_valid = '0; req_data = '0; req_last = '0;
        ser_act = 1'b0; hold_low = 1'b0; tx_done = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        prev_data = 8'h00;
        prev_any  = 1'b0;
        clr_stats();
    endtask

    task automatic rnd_round();
        logic [8:0] e;
        int ptr, pick, np, len;
        do_reset();
        exp_q.delete();
        for (int i = 0; i < NREQ; i++) begin
            mq[i].delete();
            np = $urandom_range(3, 0);
            for (int p = 0; p < np; p++) begin
                len = $urandom_range(4, 1);
                for (int b = 0; b < len; b++) begin
                    e = {b == len - 1, 8'($urandom)};
                    rq[i].push_back(e);
                    mq[i].push_back(e);
                end
            end
        end
        // Whole packets leave in round-robin order from the pointer.
        ptr = 0;
        while (1) begin
            pick = -1;
            for (int k = 0; k < NREQ; k++)
                if (pick < 0 && mq[(ptr + k) % NREQ].size() > 0)
                    pick = (ptr + k) % NREQ;
            if (pick < 0) break;
            do begin
                e = mq[pick].pop_front();
                exp_q.push_back(e[7:0]);
            end while (!e[8]);
            ptr = (pick + 1) % NREQ;
        end
        en = '1;
        run_until_idle(3000, "rnd");
        check_line("rnd");
        check("rnd_starts", 32'(n_start), 32'(exp_q.size()));
        check("rnd_start_busy", 32'(n_start_busy), 32'd0);
        check("rnd_multi_ready", 32'(n_multi), 32'd0);
        check("rnd_grant_rules", 32'(n_bad_grant), 32'd0);
        check("rnd_data_stable", 32'(n_unstable), 32'd0);
        check("rnd_no_timeout", 32'(n_to), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        tx_done = 1'b1; en = '0; xfer = '0; hold_low = 1'b0; ser_act = 1'b0;
        req_valid = '0; req_data = '0; req_last = '0; cyc = 0; done_rise = 0;
        clr_stats();

        // Low done blocks Idle acceptance, then a single-byte packet.
        do_reset();
        hold_low = 1'b1;
        en = '1;
        rq[0].push_back({1'b1, 8'h41});
        repeat (8) step();
        check("blk_ready", 32'(n_ready_cyc), 32'd0);
        check("blk_start", 32'(n_start), 32'd0);
        hold_low = 1'b0;
        run_until_idle(500, "single");
        exp_q = '{8'h41};
        check_line("single");
        check("single_grant", 32'(g_first), 32'd1);
        check("single_grant_end", 32'(grant), 32'd0);

        // Pointer moved past req0, so req1 goes before req0.
        line.delete();
        rq[0].push_back({1'b1, 8'h42});
        rq[1].push_back({1'b1, 8'h43});
        run_until_idle(500, "ptr");
        exp_q = '{8'h43, 8'h42};
        check_line("ptr");

        // Lock timeout: req0 stalls mid-packet, req1 waits.
        do_reset();
        en = '1;
        rq[0].push_back({1'b0, 8'h55});
        rq[1].push_back({1'b1, 8'h66});
        run_until_idle(1000, "tmo");
        exp_q = '{8'h55, 8'h66};
        check_line("tmo");
        check("tmo_pulses", 32'(n_to), 32'd1);
        check("tmo_delay", 32'(to_delay), 32'(TMO) + 32'd1);
        check("tmo_r1_early", 32'(n_r1_early), 32'd0);
        check("tmo_grant", 32'(g_first), 32'd1);

        for (int r = 0; r < 6; r++) rnd_round();

        // Reset while req1 holds the lock and req0 is waiting.
        do_reset();
        en = '1;
        rq[0].push_back({1'b1, 8'h77});
        run_until_idle(500, "pre");
        line.delete();
        rq[1].push_back({1'b0, 8'h11});
        k = 0;
        while (k < 500 && !(line.size() == 1 && !ser_act)) begin
            step();
            k++;
        end
        check("hold_reach", 32'(k < 500), 32'd1);
        rq[0].push_back({1'b1, 8'h21});
        repeat (4) step();
        check("hold_grant", 32'(grant), 32'h2);
        check("hold_busy", 32'(busy), 32'd1);
        check("hold_rules", 32'(n_bad_grant), 32'd0);
        do_reset();
        en = '1;
        rq[0].push_back({1'b1, 8'h21});
        rq[1].push_back({1'b1, 8'h12});
        run_until_idle(500, "post");
        exp_q = '{8'h21, 8'h12};
        check_line("post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/trace_tx_sched.md
# trace_tx_sched

Multi-requester byte scheduler for the trace UART transmit path. Arbitrates N byte-stream sources (CPU MMIO trace writes, debug dumpers) onto one `uart_tx` serializer, round-robin between packets, locking the grant until a packet's last byte. Sits between the trace MMIO sources and `uart_tx`: drives `data_i`/`tx_start_i` and consumes `tx_done_o`.

## Interface
Parameters:
- `NREQ`, 2: number of requesters (2..8).
- `LOCK_TIMEOUT`, 16'd50000: clocks a locked grant may wait for its owner's next byte before the lock is forcibly released; 0 disables the timeout.

Ports:
- `clk_i`  in  1  system clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `req_valid_i`  in  NREQ  requester i has a byte.
- `req_data_i`  in  NREQ×8  byte per requester.
- `req_last_i`  in  NREQ  byte is the final byte of its packet.
- `req_ready_o`  out  NREQ  byte accepted this cycle (transfer = valid & ready).
- `tx_data_o`  out  8  byte to serializer `data_i`.
- `tx_start_o`  out  1  one-cycle start pulse to serializer `tx_start_i`.
- `tx_done_i`  in  1  serializer idle (`tx_done_o`).
- `grant_o`  out  NREQ  one-hot current owner; 0 when none.
- `busy_o`  out  1  high in any state except Idle.
- `lock_timeout_o`  out  1  one-cycle pulse when a lock is forcibly released.

## Operation
- States: Idle, Launch, WaitBusy, WaitDone, Hold.
- Idle: if any `req_valid_i` and `tx_done_i`=1, pick winner = first valid at or after `rr_ptr` (wrapping). Assert `req_ready_o[winner]` combinationally that cycle; latch data into `tx_data_o`, set `grant_o`, latch `last` flag -> Launch.
- Launch: `tx_start_o`=1 for exactly this cycle -> WaitBusy.
- WaitBusy: wait for `tx_done_i`=0 (serializer left idle) -> WaitDone. Serializer's done stays high the cycle after start; it must not be taken as completion.
- WaitDone: on `tx_done_i`=1: if latched last=1, `rr_ptr` = owner+1 mod NREQ, `grant_o`=0 -> Idle; else -> Hold, lock counter cleared.
- Hold: `req_ready_o[owner]` = `req_valid_i[owner]`; on transfer latch byte/last -> Launch. Other requesters never get ready. Lock counter increments each Hold cycle; on reaching `LOCK_TIMEOUT` (nonzero): pulse `lock_timeout_o`, `rr_ptr` = owner+1, `grant_o`=0 -> Idle.
- At most one `req_ready_o` bit set per cycle; none set outside Idle/Hold.
- `rr_ptr` width clog2(NREQ), wraps NREQ-1 -> 0; advances only on packet end or timeout, never mid-packet.
- Single-byte packets (last=1 on first byte) release immediately after completion.
- Valid deasserting in Idle before acceptance: no effect (no transfer occurred).

## Timing
- Reset (async, any state): state Idle, `rr_ptr`=0, `tx_data_o`=0, `tx_start_o`=0, `grant_o`=0, `busy_o`=0, `lock_timeout_o`=0, `req_ready_o`=0, lock counter 0. Reset mid-frame aborts tracking; serializer is reset on the same net.
- Accept at cycle T -> `tx_start_o` high T+1 -> WaitBusy T+2.
- Next byte of locked packet: done seen at cycle D -> Hold D+1 (accept possible D+1) -> start D+2. Inter-frame gap: 2 idle clocks beyond serializer stop bit.
- Idle arbitration also needs `tx_done_i`=1; a low done in Idle blocks acceptance.
- `tx_data_o` stable from T+1 until the next acceptance.

## Structure
- Package `trace_pkg`: `trace_sched_state_t` enum, `TRACE_LOCK_TIMEOUT_DEFAULT` constant.
- Sub-module `rr_pick` (combinational): inputs valid vector and pointer, outputs one-hot winner and any-valid; reusable elsewhere in MMIO.

## Test plan
- Single byte: req0 valid 0x41 last=1 with real `uart_tx` div=0 -> one frame 0x41 on line, `grant_o` 01 then 00, `rr_ptr`=1.
- Fairness: req0 and req1 both send continuous single-byte packets 0xA0/0xB0 -> line alternates A0,B0,A0,B0; req0 first after reset.
- Lock: req0 3-byte packet 11,22,33 (last on 33), req1 valid 0x99 throughout -> line 11,22,33,99; `req_ready_o[1]` never high before 33 completes.
- Timeout: LOCK_TIMEOUT=20, req0 sends 0x55 last=0 then drops valid -> `lock_timeout_o` pulses 20 clocks into Hold, req1's pending 0x66 sent next.
- Start handshake: model holding `tx_done_i` high 3 extra cycles after start -> exactly one `tx_start_o` pulse, no premature completion.
- Async reset mid-Hold with req valid -> all outputs 0 immediately; after release req0 wins first.
